// File: rtl/adc_sched_pkg.sv
// Shared types and channel-selection helpers for the ADC channel scheduler.
package adc_sched_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam int MAX_CH = 8;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] first_channel(input logic [MAX_CH-1:0] mask, input int n);
        logic [2:0] r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n && mask[3'(i)]) r = 3'(i);
        end
        return r;
    endfunction

    // Next set bit strictly after cur, wrapping; returns cur itself when it is the only one set.
    function automatic logic [2:0] next_channel(input logic [MAX_CH-1:0] mask,
                                                input logic [2:0]        cur,
                                                input int                n);
        logic [2:0] r;
        logic       found;
        int         idx;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= n && !found) begin
                idx = (int'(cur) + i) % n;
                if (mask[3'(idx)]) begin
                    r     = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Small synchronous FIFO holding channel-tagged ADC results; head is read combinationally.
module adc_result_fifo
    import adc_sched_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is only taken when the head is leaving in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin scan sequencer for the SAR ADC: drives mux/averaging, discards settling
// conversions and queues tagged results for the backend.
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int RES_BITS   = 12,
    parameter int DISCARD    = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [N_CH-1:0]     ch_mask_i,
    input  logic [3*N_CH-1:0]   avg_cfg_i,
    input  logic                adc_done_i,
    input  logic [RES_BITS-1:0] adc_result_i,
    output logic                adc_rst_n_o,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic [2:0]          avg_control_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [RES_BITS-1:0] res_data_o,
    output logic [CH_W-1:0]     res_ch_o,
    output logic                overflow_o,
    output logic                busy_o
);

    state_t                   state;
    logic [2:0]               discard_cnt;
    logic [2:0]               avg_arr [N_CH];
    logic [CH_W-1:0]          first_ch;
    logic [CH_W-1:0]          next_ch;
    logic                     leave_run;
    logic                     accept;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CH_W+RES_BITS-1:0] fifo_dout;

    for (genvar k = 0; k < N_CH; k++) begin : g_avg
        assign avg_arr[k] = avg_cfg_i[3*k +: 3];
    end

    assign first_ch = CH_W'(first_channel(MAX_CH'(ch_mask_i), N_CH));
    assign next_ch  = CH_W'(next_channel(MAX_CH'(ch_mask_i), 3'(ch_sel_o), N_CH));

    // Dropping out of RUN wins over a coincident strobe, so that result is never queued.
    assign leave_run = (state == RUN) && (!enable_i || (ch_mask_i == '0));
    assign accept    = (state == RUN) && !leave_run && adc_done_i && (discard_cnt == 3'd0);
    assign fifo_push = accept;
    assign fifo_pop  = res_valid_o && res_ready_i;

    assign res_valid_o            = !fifo_empty;
    assign {res_ch_o, res_data_o} = fifo_dout;

    adc_result_fifo #(
        .WIDTH (CH_W + RES_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({ch_sel_o, adc_result_i}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Mux select and averaging change on the accepted strobe edge; the SAR samples them a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            adc_rst_n_o   <= 1'b0;
            ch_sel_o      <= '0;
            avg_control_o <= '0;
            discard_cnt   <= '0;
            overflow_o    <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) overflow_o <= 1'b1;
            case (state)
                IDLE: begin
                    adc_rst_n_o <= 1'b0;
                    busy_o      <= 1'b0;
                    if (enable_i && (ch_mask_i != '0)) begin
                        state         <= ARM;
                        ch_sel_o      <= first_ch;
                        avg_control_o <= avg_arr[first_ch];
                        discard_cnt   <= 3'(DISCARD);
                        overflow_o    <= 1'b0;
                        busy_o        <= 1'b1;
                    end
                end
                ARM: begin
                    state       <= RUN;
                    adc_rst_n_o <= 1'b1;
                end
                RUN: begin
                    if (leave_run) begin
                        state       <= IDLE;
                        adc_rst_n_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end else if (adc_done_i) begin
                        if (discard_cnt != 3'd0) begin
                            discard_cnt <= discard_cnt - 3'd1;
                        end else if (next_ch != ch_sel_o) begin
                            ch_sel_o      <= next_ch;
                            avg_control_o <= avg_arr[next_ch];
                            discard_cnt   <= 3'(DISCARD);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
